// File: rtl/if_fetch_redirect_pkg.sv
// Shared definitions for the IF-stage fetch/redirect slice: the fetch FSM
// state encoding, the reset PC and the instruction word used for faults.
package if_fetch_redirect_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    CANCEL = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_redirect_if.sv
// SRAM-like instruction port: one request/address phase and one data phase.
// The fetch unit is the master, the instruction memory is the slave.
interface if_fetch_redirect_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_fetch_redirect_redirect_buf.sv
// Holds pending flush and branch redirects and picks the next fetch PC.
// Priority: live flush, pending flush, pending branch, sequential pc+4.
module if_redirect_buf
  import if_fetch_redirect_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] pc,
  input  logic        take,
  output logic [31:0] next_pc,
  output logic        redir_v
);

  logic [31:0] redir_pc;
  logic        br_pend;
  logic [31:0] br_pc;

  // Priority mux selecting the PC used on the next transition into REQ.
  always_comb begin
    next_pc = pc + 32'd4;
    if (flush) begin
      next_pc = flush_pc;
    end else if (redir_v) begin
      next_pc = redir_pc;
    end else if (br_pend) begin
      next_pc = br_pc;
    end
  end

  // Record/consume redirects; a newer flush overwrites and kills any branch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      redir_v  <= 1'b0;
      redir_pc <= 32'd0;
      br_pend  <= 1'b0;
      br_pc    <= 32'd0;
    end else begin
      if (take) begin
        if (flush || redir_v) begin
          redir_v <= 1'b0;
          br_pend <= 1'b0;
        end else if (br_pend) begin
          br_pend <= 1'b0;
        end
      end else if (flush) begin
        redir_v  <= 1'b1;
        redir_pc <= flush_pc;
        br_pend  <= 1'b0;
      end
      if (br_taken && !flush) begin
        br_pend <= 1'b1;
        br_pc   <= br_target;
      end
    end
  end

endmodule

// File: rtl/if_fetch_redirect.sv
// IF-stage PC generator and fetch controller. Keeps at most one fetch in
// flight, throws away fetches made stale by a flush, and tags misaligned
// PCs with AdEL instead of fetching them.
module if_fetch_redirect #(
  parameter logic [31:0] RESET_PC = if_fetch_redirect_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = if_fetch_redirect_pkg::NOP_INST
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       id_allow_in,
  if_fetch_redirect_if.master        inst,
  output logic                       if_valid,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_inst,
  output logic                       if_adel,
  output logic [31:0]                if_badaddr
);

  import if_fetch_redirect_pkg::*;

  fetch_state_t state;
  fetch_state_t state_n;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         redir_v;
  logic         take;
  logic         capture;
  logic         adel_set;
  logic         misaligned;

  assign misaligned     = |pc[1:0];
  assign inst.inst_req  = (state == REQ) && !misaligned;
  assign inst.inst_addr = pc;
  assign if_pc          = pc;

  if_redirect_buf u_redirect_buf (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc),
    .take      (take),
    .next_pc   (next_pc),
    .redir_v   (redir_v)
  );

  // Fetch FSM next-state: 'take' marks every transition that loads a new PC.
  always_comb begin
    state_n  = state;
    take     = 1'b0;
    capture  = 1'b0;
    adel_set = 1'b0;
    case (state)
      REQ: begin
        if (misaligned) begin
          if (flush || redir_v) begin
            take = 1'b1;
          end else begin
            adel_set = 1'b1;
            state_n  = HOLD;
          end
        end else if (inst.inst_addr_ok) begin
          state_n = (flush || redir_v) ? CANCEL : WAIT;
        end
      end
      WAIT: begin
        if (inst.inst_data_ok) begin
          if (flush) begin
            take    = 1'b1;
            state_n = REQ;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (flush) begin
          state_n = CANCEL;
        end
      end
      CANCEL: begin
        if (inst.inst_data_ok) begin
          take    = 1'b1;
          state_n = REQ;
        end
      end
      HOLD: begin
        if (flush || id_allow_in) begin
          take    = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

  // State, PC and the registered instruction presented to ID.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= REQ;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_inst    <= 32'd0;
      if_adel    <= 1'b0;
      if_badaddr <= 32'd0;
    end else begin
      state    <= state_n;
      if_valid <= (state_n == HOLD);
      if (take) begin
        pc <= next_pc;
      end
      if (capture) begin
        if_inst    <= inst.inst_rdata;
        if_adel    <= 1'b0;
        if_badaddr <= 32'd0;
      end else if (adel_set) begin
        if_inst    <= NOP_INST;
        if_adel    <= 1'b1;
        if_badaddr <= pc;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed bench for if_fetch_redirect: steps the fetch FSM through normal
// fetches, flush cancellation, branch redirect, AdEL, ID stall and reset.
module tb_if_fetch_redirect;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_allow_in;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic [31:0] if_badaddr;

  int compared;
  int mismatched;

  if_fetch_redirect_if bus ();

  if_fetch_redirect dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_allow_in (id_allow_in),
    .inst        (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_adel     (if_adel),
    .if_badaddr  (if_badaddr)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic f, input logic [31:0] fpc,
                               input logic bt, input logic [31:0] btgt,
                               input logic dok, input logic [31:0] rdata);
    flush            = f;
    flush_pc         = fpc;
    br_taken         = bt;
    br_target        = btgt;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    compared           = 0;
    mismatched         = 0;
    resetn             = 1'b0;
    id_allow_in        = 1'b1;
    bus.inst_addr_ok   = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_adel", {31'd0, if_adel}, 32'd0);
    checkOutput("rst_inst", if_inst, 32'd0);
    checkOutput("rst_badaddr", if_badaddr, 32'd0);
    checkOutput("rst_addr", bus.inst_addr, 32'hBFC0_0000);

    // First fetch: REQ, WAIT, HOLD
    resetn           = 1'b1;
    bus.inst_addr_ok = 1'b1;
    checkOutput("f0_req", {31'd0, bus.inst_req}, 32'd1);
    tick();
    checkOutput("f0_wait_req", {31'd0, bus.inst_req}, 32'd0);
    checkOutput("f0_wait_valid", {31'd0, if_valid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1111_0000);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("f0_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("f0_pc", if_pc, 32'hBFC0_0000);
    checkOutput("f0_inst", if_inst, 32'h1111_0000);
    tick();

    // Second fetch is flushed while waiting; its late data must be dropped
    checkOutput("f1_addr", bus.inst_addr, 32'hBFC0_0004);
    checkOutput("f1_req", {31'd0, bus.inst_req}, 32'd1);
    checkOutput("f1_valid", {31'd0, if_valid}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'hBFC0_0380, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("cancel_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("cancel_req", {31'd0, bus.inst_req}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("flush_addr", bus.inst_addr, 32'hBFC0_0380);
    checkOutput("flush_req", {31'd0, bus.inst_req}, 32'd1);
    checkOutput("flush_drop_valid", {31'd0, if_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h2222_0380);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("vec_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("vec_pc", if_pc, 32'hBFC0_0380);
    checkOutput("vec_inst", if_inst, 32'h2222_0380);
    tick();

    // Branch resolved while its delay slot is in WAIT
    checkOutput("ds_addr", bus.inst_addr, 32'hBFC0_0384);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'hBFC0_0100, 1'b1, 32'h3333_0384);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("ds_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("ds_pc", if_pc, 32'hBFC0_0384);
    checkOutput("ds_inst", if_inst, 32'h3333_0384);
    tick();
    checkOutput("br_addr", bus.inst_addr, 32'hBFC0_0100);
    checkOutput("br_req", {31'd0, bus.inst_req}, 32'd1);
    tick();

    // Branch and flush together: flush wins, branch target is never fetched
    applyStimulus(1'b1, 32'h8000_1000, 1'b1, 32'hBFC0_0200, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_0100);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("bf_addr", bus.inst_addr, 32'h8000_1000);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h4444_1000);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("bf_pc", if_pc, 32'h8000_1000);
    checkOutput("bf_inst", if_inst, 32'h4444_1000);
    tick();
    checkOutput("bf_seq_addr", bus.inst_addr, 32'h8000_1004);
    tick();

    // Flush to a misaligned target: AdEL without a request
    applyStimulus(1'b1, 32'h8000_0002, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_1004);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    id_allow_in = 1'b0;
    checkOutput("adel_noreq", {31'd0, bus.inst_req}, 32'd0);
    tick();
    checkOutput("adel_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("adel_flag", {31'd0, if_adel}, 32'd1);
    checkOutput("adel_inst", if_inst, 32'h0000_0000);
    checkOutput("adel_badaddr", if_badaddr, 32'h8000_0002);
    checkOutput("adel_pc", if_pc, 32'h8000_0002);
    checkOutput("adel_hold_noreq", {31'd0, bus.inst_req}, 32'd0);

    // Flush out of HOLD even though ID is not allowing
    applyStimulus(1'b1, 32'hBFC0_0010, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("hflush_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("hflush_addr", bus.inst_addr, 32'hBFC0_0010);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h5555_0010);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("stall_adel_clr", {31'd0, if_adel}, 32'd0);

    // ID stalls for five cycles: output held, no new request
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d_valid", i), {31'd0, if_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_pc", i), if_pc, 32'hBFC0_0010);
      checkOutput($sformatf("stall%0d_inst", i), if_inst, 32'h5555_0010);
      checkOutput($sformatf("stall%0d_req", i), {31'd0, bus.inst_req}, 32'd0);
      tick();
    end
    id_allow_in = 1'b1;
    tick();
    checkOutput("release_addr", bus.inst_addr, 32'hBFC0_0014);
    checkOutput("release_req", {31'd0, bus.inst_req}, 32'd1);
    tick();

    // Reset while in WAIT; a stray data_ok afterwards is ignored
    resetn = 1'b0;
    tick();
    checkOutput("wrst_addr", bus.inst_addr, 32'hBFC0_0000);
    checkOutput("wrst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("wrst_inst", if_inst, 32'd0);
    resetn           = 1'b1;
    bus.inst_addr_ok = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_0000);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("stray_req", {31'd0, bus.inst_req}, 32'd1);
    checkOutput("stray_addr", bus.inst_addr, 32'hBFC0_0000);
    checkOutput("stray_valid", {31'd0, if_valid}, 32'd0);
    bus.inst_addr_ok = 1'b1;
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h6666_0000);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("post_rst_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("post_rst_pc", if_pc, 32'hBFC0_0000);
    checkOutput("post_rst_inst", if_inst, 32'h6666_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_fetch_redirect.md
Name: if_fetch_redirect

Overview:
- IF-stage PC generator and instruction-fetch controller, directly upstream of the ID/EX/MEM exception path.
- Consumes the MEM-stage flush/redirect (exception entry or ERET) and the ID-stage branch decision.
- Drives an SRAM-like instruction port with at most one request outstanding. Discards fetches made stale by a flush.
- Delivers {pc, inst, fetch-exception} to ID under a valid/allow-in handshake. Misaligned PCs are tagged AdEL instead of being fetched.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset.
NOP_INST, 32'h00000000, instruction word delivered with a fetch exception.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  MEM-stage clear_pipeline (exception or ERET)
flush_pc  in  32  redirect target (exception vector or EPC)
br_taken  in  1  ID branch taken; the instruction currently in IF is its delay slot
br_target  in  32  branch target
id_allow_in  in  1  ID can accept an instruction this cycle
inst_req  out  1  fetch request
inst_addr  out  32  fetch address; held stable while inst_req && !inst_addr_ok
inst_addr_ok  in  1  request accepted
inst_data_ok  in  1  read data returned
inst_rdata  in  32  read data
if_valid  out  1  IF holds an instruction for ID
if_pc  out  32  its PC
if_inst  out  32  its instruction word
if_adel  out  1  fetch address error; feeds exception_fetch/AdEL in ID
if_badaddr  out  32  faulting address (equals if_pc when if_adel=1)

Behaviour:
- Reset is decided: resetn, synchronous, active-low, on clock clk.
- Reset values: state=REQ, pc=RESET_PC, redir_v=0, br_pend=0, if_valid=0, if_adel=0, if_inst=0, if_badaddr=0. The first request issues in the first cycle after reset release.
- Internal registers:
  - pc: current fetch PC.
  - redir_v / redir_pc: pending flush target. A later flush overwrites it, so the latest flush wins.
  - br_pend / br_pc: pending branch target.
  - inst_buf.
- Next PC, used on every transition into REQ, in priority order:
  1. flush this cycle: flush_pc
  2. redir_v: redir_pc
  3. br_pend: br_pc
  4. otherwise: pc+4 (32-bit wrap)
  - Taking a source clears its pending flag. Taking flush or redir_v also clears br_pend.
- br_taken sets br_pend/br_pc in any state unless flush is asserted in the same cycle. Flush wins and clears br_pend.
- States:
  - REQ:
    - If pc[1:0]!=0: inst_req=0. Go to HOLD next cycle with if_adel=1, if_inst=NOP_INST, if_badaddr=pc.
    - Otherwise inst_req=1, inst_addr=pc.
    - On inst_addr_ok: go to CANCEL if flush or redir_v, else WAIT.
    - Flush without addr_ok: record redir, keep inst_addr unchanged.
  - WAIT: inst_req=0.
    - inst_data_ok && !flush: capture inst_rdata into HOLD.
    - inst_data_ok && flush: discard data, go to REQ at flush_pc.
    - Flush without data_ok: record redir, go to CANCEL.
  - CANCEL: inst_req=0, if_valid=0. On inst_data_ok, drop the data and go to REQ at the next PC (redir_pc).
  - HOLD: if_valid=1.
    - id_allow_in && !flush: handoff; go to REQ with the next PC.
    - Flush: if_valid=0 next cycle, go to REQ at flush_pc. Any same-cycle handoff is void, because ID is flushed too.
- Fetch latency: data_ok may arrive at the earliest one cycle after addr_ok. Best case is 3 cycles per instruction (REQ, WAIT, HOLD) when ID always allows.
- inst_data_ok in REQ or HOLD is ignored; none can be outstanding.
- if_valid, if_pc, if_inst, if_adel and if_badaddr are registered and stable while in HOLD.
- if_valid is 0 in REQ, WAIT and CANCEL.

Decomposition:
- Shared package holds the state encoding (REQ, WAIT, CANCEL, HOLD), RESET_PC and NOP_INST.
- The exception vector stays in the existing CP0 define header.
- One sub-module, if_redirect_buf, holds redir_v/redir_pc and br_pend/br_pc plus the priority next-PC mux.

Test Plan:
- Reset release, memory with addr_ok same cycle and data_ok one cycle later, ID always allowing → fetch addresses BFC00000, BFC00004, BFC00008; if_valid pulses every 3rd cycle with matching if_inst.
- flush=1, flush_pc=BFC00380 during WAIT of BFC00004, data_ok arriving 2 cycles later → that data is dropped, if_valid never shows BFC00004, and the next inst_addr is BFC00380.
- br_taken=1, br_target=BFC00100 while the delay slot BFC0000C is in WAIT → BFC0000C is delivered, then the next request goes to BFC00100.
- br_taken and flush in the same cycle (flush_pc=80001000) → next inst_addr=80001000; the branch target is never fetched.
- flush_pc=80000002 → no inst_req; HOLD with if_adel=1, if_inst=0, if_badaddr=80000002.
- id_allow_in=0 for 5 cycles in HOLD → if_pc/if_inst stable and no new request; on allow, the next request is pc+4. Then resetn low during WAIT → state REQ, inst_addr=BFC00000, stray data_ok ignored.
